bldc_commutator_pwm: RTL and testbench

- Parametrised six-step BLDC commutation and PWM block: filters three hall inputs, decodes the rotor sector, and drives six gate outputs (three high-side, three low-side).
- Adds what the previous controller lacked: configurable duty width and PWM prescale, a direction input, a brake input, per-leg dead-time insertion, and a latched fault on invalid hall codes.
- Sits between the hall sensor pins and the gate-driver pins of the motor board.

---
 rtl/bldc_commutator_pwm.sv | 126 ++++++++++++
 tb/tb_bldc_commutator_pwm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_commutator_pwm.sv
// bldc_commutator_pwm: hall-filtered six-step BLDC commutator with PWM, dead time and latched hall fault.
// Define BLDC_SEQ_CHECK_EN to also fault on accepted sector jumps other than 0/+-1.
module bldc_commutator_pwm #(
   parameter int DUTY_W      = 4,
   parameter int PRESCALE    = 1,
   parameter int HALL_FILT   = 4,
   parameter int DEAD_CYCLES = 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              H1,
   input  logic              H2,
   input  logic              H3,
   input  logic [DUTY_W-1:0] DUTY,
   input  logic              DIR,
   input  logic              EN,
   input  logic              BRAKE,
   output logic [2:0]        HI,
   output logic [2:0]        LO,
   output logic [2:0]        SECTOR,
   output logic              STEP,
   output logic              FAULT
);
   localparam int PW = $clog2(PRESCALE + 1);
   localparam int FW = $clog2(HALL_FILT + 1);
   localparam int DW = $clog2(DEAD_CYCLES + 1);
   localparam logic [DUTY_W-1:0] CNT_MAX = DUTY_W'((1 << DUTY_W) - 2);
   logic [2:0] s1, s2, cand, code, new_sec, plus, minus, cmd_hi, cmd_lo, hi_n, lo_n, dz;
   logic [5:0] tbl;
   logic [FW-1:0] cnt, cnt_n;
   logic [PW-1:0] pre;
   logic [DUTY_W-1:0] pwm_cnt, duty_q;
   logic [DW-1:0] dc [3];
   logic tick, wrap, pwm_on, accept, seq_bad;
   function automatic logic [2:0] decode(input logic [2:0] c);
      case (c)
         3'b001:  return 3'd0;
         3'b011:  return 3'd1;
         3'b010:  return 3'd2;
         3'b110:  return 3'd3;
         3'b100:  return 3'd4;
         3'b101:  return 3'd5;
         default: return 3'd7;
      endcase
   endfunction
   // cnt is the length of the current run of equal synchronized samples, saturating at HALL_FILT
   assign cnt_n   = (s2 != cand) ? FW'(1) : (cnt == FW'(HALL_FILT)) ? cnt : cnt + 1'b1;
   assign accept  = (cnt_n == FW'(HALL_FILT)) && (s2 != code);
   assign new_sec = decode(s2);
   assign tick    = pre == PW'(PRESCALE - 1);
   assign wrap    = pwm_cnt == CNT_MAX;
   assign pwm_on  = pwm_cnt < duty_q;
`ifdef BLDC_SEQ_CHECK_EN
   logic [2:0] last_sec;
   logic armed;
   assign seq_bad = armed && new_sec != 3'd7 && new_sec != last_sec
                    && new_sec != ((last_sec == 3'd5) ? 3'd0 : last_sec + 3'd1)
                    && new_sec != ((last_sec == 3'd0) ? 3'd5 : last_sec - 3'd1);
   always_ff @(posedge CLK) begin
      if (RST || !EN) begin
         armed    <= 1'b0;
         last_sec <= 3'd0;
      end else if (accept && new_sec != 3'd7) begin
         armed    <= 1'b1;
         last_sec <= new_sec;
      end
   end
`else
   assign seq_bad = 1'b0;
`endif
   // {positive leg, negative leg} for forward rotation
   always_comb
      case (SECTOR)
         3'd0:    tbl = 6'b001_010;
         3'd1:    tbl = 6'b001_100;
         3'd2:    tbl = 6'b010_100;
         3'd3:    tbl = 6'b010_001;
         3'd4:    tbl = 6'b100_001;
         3'd5:    tbl = 6'b100_010;
         default: tbl = 6'b000_000;
      endcase
   assign plus   = DIR ? tbl[2:0] : tbl[5:3];
   assign minus  = DIR ? tbl[5:3] : tbl[2:0];
   assign cmd_hi = (EN && !FAULT && !BRAKE && pwm_on) ? plus : 3'b000;
   assign cmd_lo = (EN && !FAULT) ? (BRAKE ? 3'b111 : minus) : 3'b000;
   // a switch may rise only after its leg has been fully off for DEAD_CYCLES, unless it is already on
   assign dz   = {dc[2] == '0, dc[1] == '0, dc[0] == '0};
   assign hi_n = cmd_hi & (HI | dz);
   assign lo_n = cmd_lo & ~hi_n & (LO | dz);
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1      <= '0;
         s2      <= '0;
         cand    <= '0;
         cnt     <= '0;
         code    <= '0;
         SECTOR  <= 3'd7;
         STEP    <= 1'b0;
         FAULT   <= 1'b0;
         pre     <= '0;
         pwm_cnt <= '0;
         duty_q  <= '0;
         HI      <= '0;
         LO      <= '0;
         for (int i = 0; i < 3; i++) dc[i] <= DW'(DEAD_CYCLES);
      end else begin
         s1    <= {H3, H2, H1};
         s2    <= s1;
         cand  <= s2;
         cnt   <= cnt_n;
         STEP  <= accept && new_sec != SECTOR;
         FAULT <= EN && (FAULT || (accept && (new_sec == 3'd7 || seq_bad)));
         if (accept) begin
            code   <= s2;
            SECTOR <= new_sec;
         end
         pre <= tick ? '0 : pre + 1'b1;
         if (tick) pwm_cnt <= wrap ? '0 : pwm_cnt + 1'b1;
         if (tick && wrap) duty_q <= DUTY;
         HI <= hi_n;
         LO <= lo_n;
         for (int i = 0; i < 3; i++)
            dc[i] <= (hi_n[i] || lo_n[i]) ? DW'(DEAD_CYCLES) : (dc[i] == '0) ? '0 : dc[i] - 1'b1;
      end
   end
endmodule

// File: tb/tb_bldc_commutator_pwm.sv
// tb_bldc_commutator_pwm: randomized scoreboard bench for bldc_commutator_pwm.
// A cycle model pushes expected outputs each edge; a negedge monitor pops and compares.
module tb_bldc_commutator_pwm;
   localparam int DW  = 4;
   localparam int PS  = 1;
   localparam int HF  = 4;
   localparam int DC  = 3;
   localparam int PER = (1 << DW) - 1;
   localparam logic [2:0] CODE [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
   localparam int NEG [6] = '{1, 2, 2, 0, 0, 1};
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] hall = 3'b001;
   logic [DW-1:0] duty = 4'd5;
   logic dir = 1'b0, en = 1'b1, brake = 1'b0;
   logic [2:0] hi, lo, sector;
   logic step, fault;
   int checks = 0, failures = 0;
   bldc_commutator_pwm #(.DUTY_W(DW), .PRESCALE(PS), .HALL_FILT(HF), .DEAD_CYCLES(DC)) dut (
      .CLK(clk), .RST(rst), .H1(hall[0]), .H2(hall[1]), .H3(hall[2]), .DUTY(duty),
      .DIR(dir), .EN(en), .BRAKE(brake), .HI(hi), .LO(lo), .SECTOR(sector),
      .STEP(step), .FAULT(fault));
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask
   // reference model state
   logic [2:0] d1, d2, m_code, m_hi, m_lo;
   logic [2:0] win [$];
   int m_sec, k, duty_lat, last_sec;
   int off_run [3];
   logic m_step, m_fault, armed;
   logic [10:0] exp_q [$];
   function automatic int dec(input logic [2:0] c);
      for (int s = 0; s < 6; s++) if (CODE[s] == c) return s;
      return 7;
   endfunction
   task automatic model_reset();
      d1 = 0; d2 = 0; win.delete(); m_code = 0; m_sec = 7; m_step = 0; m_fault = 0;
      m_hi = 0; m_lo = 0; k = 0; duty_lat = 0; armed = 0; last_sec = 0;
      for (int i = 0; i < 3; i++) off_run[i] = 0;
   endtask
   task automatic model_edge();
      logic [2:0] samp, ph, pl, ch, cl;
      int ns;
      bit acc, bad, nh, nl;
      ph = 0; pl = 0; ch = 0; cl = 0;
      if (m_sec < 6) begin
         ph = 3'(1 << (m_sec / 2));
         pl = 3'(1 << NEG[m_sec]);
         if (dir) {ph, pl} = {pl, ph};
      end
      if (en && !m_fault) begin
         cl = brake ? 3'b111 : pl;
         ch = (brake || ((k / PS) % PER) >= duty_lat) ? 3'b000 : ph;
      end
      for (int i = 0; i < 3; i++) begin
         nh = ch[i] && (m_hi[i] || off_run[i] >= DC);
         nl = cl[i] && (m_lo[i] || off_run[i] >= DC);
         off_run[i] = (nh || nl) ? 0 : off_run[i] + 1;
         m_hi[i] = nh;
         m_lo[i] = nl;
      end
      if (k % PS == PS - 1 && (k / PS) % PER == PER - 1) duty_lat = int'(duty);
      samp = d2; d2 = d1; d1 = hall;
      win.push_back(samp);
      if (win.size() > HF) void'(win.pop_front());
      acc = (win.size() == HF) && (samp != m_code);
      foreach (win[j]) if (win[j] != samp) acc = 0;
      ns = dec(samp);
`ifdef BLDC_SEQ_CHECK_EN
      bad = armed && ns < 6 && (((ns - last_sec + 6) % 6) inside {2, 3, 4});
`else
      bad = 0;
`endif
      m_step = acc && ns != m_sec;
      if (!en) m_fault = 0;
      else if (acc && (ns == 7 || bad)) m_fault = 1;
      if (!en) armed = 0;
      else if (acc && ns < 6) begin
         armed = 1;
         last_sec = ns;
      end
      if (acc) begin
         m_code = samp;
         m_sec = ns;
      end
      k++;
   endtask
   initial forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      exp_q.push_back({m_hi, m_lo, 3'(m_sec), m_step, m_fault});
   end
   initial forever begin
      logic [10:0] e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("outputs{hi,lo,sector,step,fault}", 32'({hi, lo, sector, step, fault}), 32'(e));
         check("shoot_through", 32'(hi & lo), 32'd0);
      end
   end
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   initial begin
      int cnt, cur, r;
      cyc(3);
      check("reset_hi", 32'(hi), 0);
      check("reset_lo", 32'(lo), 0);
      check("reset_sector", 32'(sector), 7);
      check("reset_fault", 32'(fault), 0);
      rst = 0;
      cyc(1 + HF);
      check("latency_before", 32'(sector), 7);
      cyc(1);
      check("latency_at", 32'(sector), 0);
      cyc(60);
      cnt = 0;
      repeat (150) begin
         @(negedge clk);
         cnt += int'(hi[0]);
      end
      check("duty5_count", 32'(cnt), 50);
      check("sector0_lo", 32'(lo), 32'b010);
      duty = 0;
      cyc(40);
      cnt = 0;
      repeat (30) begin
         @(negedge clk);
         cnt += int'(hi[0]);
      end
      check("duty0_count", 32'(cnt), 0);
      duty = 4'hF;
      cyc(40);
      cnt = 0;
      repeat (30) begin
         @(negedge clk);
         cnt += int'(hi[0]);
      end
      check("duty15_count", 32'(cnt), 30);
      duty = 5;
      cnt = 0;
      for (int s = 1; s <= 6; s++) begin
         hall = CODE[s % 6];
         repeat (200) begin
            @(negedge clk);
            cnt += int'(step);
         end
      end
      check("rotation_steps", 32'(cnt), 6);
      hall = CODE[1];
      cyc(200);
      hall = CODE[2];
      cyc(200);
      dir = 1;
      cyc(100);
      check("dir1_lo", 32'(lo), 32'b010);
      check("dir1_hi", 32'(hi & 3'b011), 0);
      dir = 0;
      cyc(50);
      hall = 3'b000;
      cyc(2);
      hall = CODE[2];
      cyc(20);
      check("glitch_sector", 32'(sector), 2);
      check("glitch_fault", 32'(fault), 0);
      hall = 3'b000;
      cyc(10);
      check("invalid_fault", 32'(fault), 1);
      check("invalid_gates", 32'({hi, lo}), 0);
      hall = CODE[2];
      cyc(20);
      check("fault_latched", 32'(fault), 1);
      check("recovered_sector", 32'(sector), 2);
      en = 0;
      cyc(2);
      check("en_clears_fault", 32'(fault), 0);
      en = 1;
      hall = CODE[0];
      cyc(20);
      hall = CODE[3];
      cyc(20);
      check("jump_sector", 32'(sector), 3);
`ifdef BLDC_SEQ_CHECK_EN
      check("jump_fault", 32'(fault), 1);
`else
      check("jump_fault", 32'(fault), 0);
`endif
      en = 0;
      cyc(2);
      en = 1;
      cur = 3;
      for (int n = 0; n < 150; n++) begin
         r = int'($urandom_range(99));
         if (r < 70) begin
            cur = (cur + (($urandom_range(1) == 1) ? 1 : 5)) % 6;
            hall = CODE[cur];
            cyc(int'($urandom_range(8, 30)));
         end else if (r < 80) begin
            hall = 3'($urandom_range(7));
            cyc(int'($urandom_range(1, 8)));
            hall = CODE[cur];
            cyc(8);
         end else if (r < 87) begin
            duty = DW'($urandom);
            cyc(20);
         end else if (r < 92) begin
            dir = ~dir;
            cyc(20);
         end else if (r < 95) begin
            brake = 1;
            cyc(int'($urandom_range(5, 20)));
            brake = 0;
            cyc(5);
         end else if (r < 98) begin
            en = 0;
            cyc(int'($urandom_range(1, 5)));
            en = 1;
            cyc(5);
         end else begin
            rst = 1;
            cyc(int'($urandom_range(1, 3)));
            rst = 0;
            cyc(10);
         end
      end
      cyc(3);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
